// File: rtl/mac_vector_collector.sv
// Collects rounded/saturated MAC results into 8- or 16-element vectors and
// streams each completed vector out over a valid/ready port.
module mac_vector_collector #(
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] mac_out,
  input  logic        mac_done,
  input  logic        vec_len16,
  input  logic        clr_flags,
  output logic [19:0] o_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_last,
  output logic [4:0]  elem_cnt,
  output logic        ovf,
  output logic        sat
);

  // state | meaning
  // FILL  | accepting mac_done results into buf[wr_ptr]
  // DRAIN | streaming buf[rd_ptr] out; incoming results are dropped
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic signed [24:0] RND     = 25'sd1 <<< (SHIFT - 1);
  localparam logic signed [24:0] POS_MAX = 25'sd524287;
  localparam logic signed [24:0] NEG_MIN = -25'sd524288;

  logic [0:0]  state;
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic        len16;
  logic        out_en;
  logic [19:0] mem [16];

  logic signed [24:0] ext;
  logic signed [24:0] rounded;
  logic [19:0] conv_val;
  logic        conv_sat;
  logic        wr_len16;
  logic [3:0]  wr_last_idx;
  logic [3:0]  last_idx;
  logic        wr_en;
  logic        drop;
  logic        xfer;

  always_comb begin
    ext      = {mac_out[23], mac_out};
    rounded  = (ext + RND) >>> SHIFT;
    conv_val = rounded[19:0];
    conv_sat = 1'b0;
    if (rounded > POS_MAX) begin
      conv_val = 20'h7FFFF;
      conv_sat = 1'b1;
    end else if (rounded < NEG_MIN) begin
      conv_val = 20'h80000;
      conv_sat = 1'b1;
    end
  end

  // The first write of a vector uses the live vec_len16, later writes the latched one.
  assign wr_len16    = (wr_ptr == 4'd0) ? vec_len16 : len16;
  assign wr_last_idx = wr_len16 ? 4'd15 : 4'd7;
  assign last_idx    = len16 ? 4'd15 : 4'd7;

  assign wr_en   = (state == FILL) && mac_done;
  assign drop    = (state == DRAIN) && mac_done;
  assign o_valid = (state == DRAIN) && out_en;
  assign xfer    = o_valid && o_ready;
  assign o_last  = o_valid && (rd_ptr == last_idx);
  assign o_data  = o_valid ? mem[rd_ptr] : 20'h0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= conv_val;
    end
  end

  // out_en delays o_valid by one cycle after entering DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      elem_cnt <= 5'd0;
      len16    <= 1'b0;
      out_en   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (mac_done) begin
            wr_ptr   <= wr_ptr + 4'd1;
            elem_cnt <= elem_cnt + 5'd1;
            if (wr_ptr == 4'd0) begin
              len16 <= vec_len16;
            end
            if (wr_ptr == wr_last_idx) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          out_en <= 1'b1;
          if (xfer) begin
            rd_ptr <= rd_ptr + 4'd1;
            if (o_last) begin
              rd_ptr   <= 4'd0;
              wr_ptr   <= 4'd0;
              elem_cnt <= 5'd0;
              out_en   <= 1'b0;
              state    <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      sat <= 1'b0;
    end else begin
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_flags) begin
        ovf <= 1'b0;
      end
      if (wr_en && conv_sat) begin
        sat <= 1'b1;
      end else if (clr_flags) begin
        sat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_vector_collector.sv
// Scoreboard bench for mac_vector_collector: a vector-level reference model
// queues expected outputs, a negedge monitor checks every transfer.
module tb_mac_vector_collector;
  localparam int SHIFT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] mac_out;
  logic        mac_done;
  logic        vec_len16;
  logic        clr_flags;
  logic [19:0] o_data;
  logic        o_valid;
  logic        o_ready;
  logic        o_last;
  logic [4:0]  elem_cnt;
  logic        ovf;
  logic        sat;

  always #5 clk = ~clk;

  mac_vector_collector #(.SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .mac_out(mac_out), .mac_done(mac_done),
    .vec_len16(vec_len16), .clr_flags(clr_flags), .o_data(o_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
    .elem_cnt(elem_cnt), .ovf(ovf), .sat(sat)
  );

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   cur[$];
  int   mlen;
  bit   exp_ovf, exp_sat;
  int   n_chk, n_bad, xfer_cnt;
  int   rmode;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-half-up then floor-shift, clamp to the signed 20-bit range.
  function automatic int conv(input logic [23:0] m, output bit s);
    int v, r;
    v = $signed(m);
    r = (v + (1 << (SHIFT - 1))) >>> SHIFT;
    s = 1'b0;
    if (r > 524287) begin r = 524287; s = 1'b1; end
    else if (r < -524288) begin r = -524288; s = 1'b1; end
    return r & 32'hFFFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mac_op(input logic [23:0] v, input bit clr);
    bit s, dropped;
    int cv;
    exp_t e;
    cv = conv(v, s);
    dropped = exp_q.size() > 0;
    mac_out = v;
    mac_done = 1'b1;
    clr_flags = clr;
    if (clr) begin exp_ovf = 1'b0; exp_sat = 1'b0; end
    if (dropped) exp_ovf = 1'b1;
    else begin
      if (cur.size() == 0) mlen = vec_len16 ? 16 : 8;
      cur.push_back(cv);
      if (s) exp_sat = 1'b1;
      if (cur.size() == mlen) begin
        foreach (cur[i]) begin
          e.data = cur[i];
          e.last = (i == mlen - 1);
          exp_q.push_back(e);
        end
        cur.delete();
      end
    end
    tick();
    mac_done = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic clr_op();
    clr_flags = 1'b1;
    exp_ovf = 1'b0;
    exp_sat = 1'b0;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_sat"}, sat, exp_sat);
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() > 0 && c < 400) begin
      tick();
      c++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    chk("post_drain_valid", o_valid, 0);
    chk("post_drain_cnt", elem_cnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_cnt", elem_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sat", sat, 0);
    cur.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_sat = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [23:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 24'h7FFFF0 + 24'($urandom_range(0, 15));
      1: return 24'h800000 + 24'($urandom_range(0, 15));
      2: return 24'($urandom());
      default: return 24'($urandom_range(0, 4095)) - 24'd2048;
    endcase
  endfunction

  // Ready pattern: 0 always, 1 toggling, 2 random, 3 held low.
  initial begin
    o_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: o_ready = 1'b1;
        1: o_ready = !o_ready;
        2: o_ready = 1'($urandom_range(0, 1));
        default: o_ready = 1'b0;
      endcase
    end
  end

  logic [19:0] prev_d;
  bit          prev_stall;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_valid) chk("stall_hold", o_data, prev_d);
      if (!o_valid) begin
        chk("idle_data", o_data, 0);
        chk("idle_last", o_last, 0);
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL unexpected_xfer: got data %0h with no expected element", o_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data", o_data, mon_e.data);
          chk("last", o_last, int'(mon_e.last));
        end
        xfer_cnt++;
      end
      prev_stall = o_valid && !o_ready;
      prev_d = o_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    logic [23:0] rv [4];
    rst = 1'b1; mac_out = '0; mac_done = 1'b0; vec_len16 = 1'b0; clr_flags = 1'b0;
    rmode = 0; n_chk = 0; n_bad = 0; xfer_cnt = 0;
    exp_ovf = 1'b0; exp_sat = 1'b0; mlen = 8;
    repeat (3) tick();
    do_reset();

    // Rounding and saturation directed values.
    rv[0] = 24'h000128; rv[1] = 24'hFFFFF7; rv[2] = 24'h800000; rv[3] = 24'h7FFFF8;
    for (int i = 0; i < 3; i++) mac_op(rv[i], 1'b0);
    chk("sat_after_min", sat, 0);
    mac_op(rv[3], 1'b0);
    chk("sat_after_max", sat, 1);
    for (int i = 0; i < 4; i++) mac_op(24'($urandom_range(0, 65535)), 1'b0);
    check_flags("round");
    wait_drain();
    clr_op();
    check_flags("round_clr");

    // 8 back-to-back, ready high: latency and consecutive drain.
    for (int k = 0; k < 8; k++) mac_op(24'(k * 16), 1'b0);
    chk("b2b_cnt8", elem_cnt, 8);
    chk("b2b_valid_gap", o_valid, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("b2b_valid", o_valid, 1);
      chk("b2b_last_pos", o_last, int'(i == 7));
      tick();
    end
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_fill_valid", o_valid, 0);
    chk("b2b_fill_cnt", elem_cnt, 0);

    // Next vector starts right after the last transfer: 16 with toggling ready.
    vec_len16 = 1'b1;
    rmode = 1;
    x0 = xfer_cnt;
    mac_op(rand_val(), 1'b0);
    chk("accept_after_last", elem_cnt, 1);
    for (int i = 0; i < 15; i++) mac_op(rand_val(), 1'b0);
    wait_drain();
    chk("xfers16", xfer_cnt - x0, 16);
    check_flags("v16");
    clr_op();

    // Drops during drain and clr/set priority.
    vec_len16 = 1'b0;
    rmode = 3;
    for (int i = 0; i < 8; i++) mac_op(rand_val(), 1'b0);
    tick(); tick();
    chk("drop_valid", o_valid, 1);
    mac_op(rand_val(), 1'b0);
    chk("drop_ovf", ovf, 1);
    clr_op();
    chk("clr_ovf", ovf, 0);
    mac_op(rand_val(), 1'b1);
    chk("clr_vs_drop", ovf, 1);
    rmode = 0;
    wait_drain();
    clr_op();

    // vec_len16 flip mid-vector takes effect only on the next vector.
    vec_len16 = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i < 3; i++) mac_op(rand_val(), 1'b0);
    vec_len16 = 1'b1;
    for (int i = 0; i < 5; i++) mac_op(rand_val(), 1'b0);
    chk("flip_cnt", elem_cnt, 8);
    wait_drain();
    chk("flip_xfers8", xfer_cnt - x0, 8);
    x0 = xfer_cnt;
    for (int i = 0; i < 16; i++) mac_op(rand_val(), 1'b0);
    wait_drain();
    chk("flip_xfers16", xfer_cnt - x0, 16);

    // Reset mid-fill and mid-drain.
    vec_len16 = 1'b0;
    for (int i = 0; i < 5; i++) mac_op(rand_val(), 1'b0);
    do_reset();
    rmode = 3;
    for (int i = 0; i < 8; i++) mac_op(rand_val(), 1'b0);
    tick(); tick();
    rmode = 0;
    repeat (3) tick();
    do_reset();
    rmode = 2;
    for (int i = 0; i < 8; i++) mac_op(rand_val(), 1'b0);
    wait_drain();
    check_flags("post_rst");

    // Random traffic: strobes in any state, length flips, random ready.
    for (int c = 0; c < 300; c++) begin
      vec_len16 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) mac_op(rand_val(), $urandom_range(0, 9) == 0);
      else tick();
      if (c % 50 == 0) check_flags("rand");
    end
    begin
      int g = 0;
      while ((cur.size() > 0 || exp_q.size() > 0) && g < 400) begin
        if (exp_q.size() == 0) mac_op(rand_val(), 1'b0);
        else tick();
        g++;
      end
    end
    wait_drain();
    check_flags("rand_end");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_vector_collector.md
# mac_vector_collector

Downstream stage of the MAC datapath: captures each 24-bit MAC result on its `done` pulse, rounds and saturates it to the 20-bit operand format, and assembles 8- or 16-element capsule vectors in a local buffer. A completed vector is streamed out over a valid/ready interface, with a last-element marker, to the next stage (squash unit or operand memory write-back). Results arriving while a vector is draining are dropped and flagged.

## Interface
- `SHIFT`, 4: fractional bits removed when converting 24-bit MAC results to the 20-bit format; legal range 1..4.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mac_out`  in  24: signed MAC result; sampled only when `mac_done`=1.
- `mac_done`  in  1: one-cycle strobe; `mac_out` is valid in that cycle.
- `vec_len16`  in  1: 1 = 16-element vector, 0 = 8-element; sampled on the first write of each vector.
- `clr_flags`  in  1: synchronous clear of `ovf` and `sat`.
- `o_data`  out  20: signed element at read pointer; 0 when `o_valid`=0.
- `o_valid`  out  1: element available.
- `o_ready`  in  1: consumer accepts; transfer when `o_valid & o_ready`.
- `o_last`  out  1: current element is the final element of the vector (only with `o_valid`).
- `elem_cnt`  out  5: elements written in the current vector (0..16).
- `ovf`  out  1: sticky; a `mac_done` was dropped.
- `sat`  out  1: sticky; a conversion saturated.

## Operation
- Two states: FILL, DRAIN. Reset → FILL, `wr_ptr`=`rd_ptr`=0, `elem_cnt`=0, `o_valid`=`o_last`=0, `o_data`=0, `ovf`=`sat`=0, latched length = 8.
- Conversion: sign-extend `mac_out` to 25 bits, add `1<<(SHIFT-1)`, arithmetic right shift by `SHIFT`. If the result exceeds +0x7FFFF, output 0x7FFFF; if it is below −0x80000, output 0x80000. Either case sets `sat`.
- FILL: on `mac_done`, write the converted value to `buf[wr_ptr]`, then increment `wr_ptr` and `elem_cnt`. When `wr_ptr`=0, latch `vec_len16` in the same cycle. If the written index equals len−1, go to DRAIN next cycle.
- DRAIN:
  - `o_valid`=1 and `o_data`=`buf[rd_ptr]`.
  - `o_last`=1 when `rd_ptr`=len−1.
  - On each transfer, increment `rd_ptr`.
  - On the transfer with `o_last`=1, clear both pointers and `elem_cnt`, and return to FILL.
- `mac_done` during DRAIN: the value is not written, `ovf` is set, and pointers are unaffected. This includes the final-transfer cycle; the block returns to FILL on the following cycle.
- `clr_flags` and a flag-setting event in the same cycle: set wins.
- `vec_len16` changes mid-vector: ignored until the next vector.
- `rst` mid-fill or mid-drain: buffer contents are discarded and all outputs return to reset values immediately. No partial vector is emitted.

## Timing
- `mac_done` at edge N: the element is stored at N, and `elem_cnt` reflects it after N.
- Last element stored at edge N: `o_valid`=1 from after edge N+1 (one cycle in the DRAIN transition).
- `o_data`/`o_last` are driven combinationally from the registered buffer and `rd_ptr`, with no read latency. They hold stable while `o_valid & !o_ready`.
- With `o_ready` held at 1: 8 elements drain in 8 consecutive cycles, 16 in 16. The first `mac_done` of the next vector is accepted one cycle after the last transfer.
- Minimum `mac_done` spacing: 1 cycle (back-to-back strobes accepted in FILL).

## Test plan
- Rounding and saturation (`SHIFT`=4): send the following `mac_out` values as elements, then check the drained outputs.
  - 0x000128 → 0x00013
  - 0xFFFFF7 → 0xFFFFF
  - 0x800000 → 0x80000, `sat` stays 0
  - 0x7FFFF8 → 0x7FFFF, `sat`=1
- 8-element vector, `vec_len16`=0, back-to-back `mac_done` with values 0x10·k (k=0..7), `o_ready`=1 → `o_valid` rises 1 cycle after the 8th store. Data is 0x1,0x2..0x7 with k=0 giving 0, over 8 cycles, with `o_last` only on the 8th.
- 16-element vector with `o_ready` toggling 1,0,1,0 → exactly 16 transfers in order, data stable during stalls, return to FILL, `elem_cnt`=0.
- `mac_done` during DRAIN → element dropped, `ovf`=1, drained vector unchanged. `clr_flags` → `ovf`=0. With `clr_flags` and a drop in the same cycle, `ovf` stays 1.
- `vec_len16` flips 0→1 after the 3rd element → the vector still completes at 8 elements; the next vector uses 16.
- Assert `rst` after 5 of 8 elements and again mid-drain → outputs at reset values immediately. A following full vector drains correctly from index 0.
